plic_hart_claim_master: RTL and testbench
=========================================

// Module: plic_hart_claim_master
// PURPOSE
//  APB initiator servicing one hart context of plic_top: on a pending interrupt it reads the claim register,
//  presents the ID to the core via a valid/ready handshake, then writes the completion ID back.
//  Sits between a hart's irq output (hart_mmode_irq_o/hart_smode_irq_o bit) and the PLIC APB slave port.
// PARAMETERS
//  ADDR_WIDTH  32             APB address width
//  DATA_WIDTH  32             APB data width
//  ID_WIDTH    6              interrupt ID width (NUM_IRQ=48 -> 6)
//  CLAIM_ADDR  32'hC020_0004  claim/complete register of the serviced context
//  TIMEOUT     16             max ACCESS cycles waiting for pready_i before abort
//  GAP         2              min IDLE cycles between transactions (irq settle after claim/complete)
// PORTS
//  pclk_i        in   1            APB clock
//  prst_i        in   1            async reset, active-high
//  en_i          in   1            enable new claims
//  irq_i         in   1            level interrupt from PLIC for this context
//  psel_o        out  1            APB select
//  penable_o     out  1            APB enable
//  pwrite_o      out  1            APB write
//  paddr_o       out  ADDR_WIDTH   APB address
//  pwdata_o      out  DATA_WIDTH   APB write data
//  pstrb_o       out  4            byte strobes, 4'hF on writes, 4'h0 on reads
//  pprot_o       out  3            fixed 3'b001 (privileged, secure, data)
//  prdata_i      in   DATA_WIDTH   APB read data
//  pready_i      in   1            APB ready
//  pslv_err_i    in   1            APB slave error
//  claim_valid_o out  1            claimed ID available
//  claim_ready_i in   1            core accepts ID
//  claim_id_o    out  ID_WIDTH     claimed ID
//  cmpl_valid_i  in   1            core requests completion
//  cmpl_ready_o  out  1            completion accepted
//  cmpl_id_i     in   ID_WIDTH     ID to complete
//  err_o         out  1            1-cycle pulse: pslv_err or timeout
//  busy_o        out  1            high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0 (paddr/pwdata/claim_id 0), state IDLE, gap counter loaded with GAP.
//  FSM: IDLE -> RD_SETUP -> RD_ACCESS -> HOLD -> WAIT_CMPL -> WR_SETUP -> WR_ACCESS -> IDLE.
//  IDLE: leave only when gap counter==0 && en_i && irq_i; counter reloads GAP on every entry to IDLE.
//  RD_SETUP (1 cycle): psel=1 penable=0 pwrite=0 paddr=CLAIM_ADDR. RD_ACCESS: penable=1, hold until pready_i.
//  On pready_i in RD_ACCESS: pslv_err_i -> err_o pulse, IDLE; prdata_i[ID_WIDTH-1:0]==0 (spurious) -> IDLE,
//   no claim; else latch ID -> HOLD. Upper prdata bits ignored.
//  HOLD: claim_valid_o=1, claim_id_o stable until claim_ready_i; transfer completes same cycle -> WAIT_CMPL.
//  WAIT_CMPL: cmpl_ready_o=1; cmpl_valid_i -> latch cmpl_id_i -> WR_SETUP. Any ID accepted (PLIC ignores mismatch).
//  WR_SETUP: psel=1 pwrite=1 pstrb=4'hF pwdata=zero-extended ID. WR_ACCESS: penable=1 until pready_i; -> IDLE,
//   pslv_err_i additionally pulses err_o.
//  APB outputs change only on pclk_i edges; paddr/pwrite/pwdata stable SETUP through ACCESS completion.
//  Timeout: counter counts ACCESS cycles; at TIMEOUT cycles without pready_i: drop psel/penable, err_o pulse,
//   IDLE (claim lost, software recovers). Counter width $clog2(TIMEOUT+1).
//  irq_i falling after IDLE exit: transaction still completes. en_i low mid-operation: current sequence finishes.
//  cmpl_valid_i outside WAIT_CMPL and claim_ready_i outside HOLD: ignored.
//  Async reset mid-transfer: psel_o/penable_o drop immediately, no completion issued.
// STRUCTURE
//  Package plic_master_pkg: state enum (7 states), APB prot constant, ID/width typedefs.
//  Sub-module plic_apb_xfer: single-transfer APB initiator (SETUP/ACCESS/timeout/err), req/done handshake;
//   top keeps claim/complete sequencing FSM and gap counter.
// TESTING
//  irq_i=1, slave returns prdata=2, no wait -> read @C020_0004, claim_id_o=2, then cmpl_id_i=2 -> write pwdata=2.
//  pready_i held low 3 cycles in RD_ACCESS -> penable_o held 3 extra cycles, paddr stable, ID captured on 4th.
//  prdata=0 (spurious) -> no claim_valid_o, back to IDLE, next read after GAP=2 cycles if irq_i still 1.
//  pready_i never asserted -> after 16 ACCESS cycles psel_o=0, err_o pulses 1 cycle, busy_o=0.
//  pslv_err_i=1 on completion write -> err_o pulse, FSM IDLE; claim_ready_i=0 for 5 cycles -> claim_valid_o held.
//  prst_i asserted in WR_ACCESS -> psel_o/penable_o 0 same cycle; with irq_i=1 fresh claim read after release+GAP.

Source files
------------

// File: rtl/plic_master_pkg.sv
// Shared types and constants for the PLIC hart claim/complete master.
// Holds the sequencing state encoding and the fixed APB attributes.
package plic_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_SETUP  = 3'd1,
    ST_RD_ACCESS = 3'd2,
    ST_HOLD      = 3'd3,
    ST_WAIT_CMPL = 3'd4,
    ST_WR_SETUP  = 3'd5,
    ST_WR_ACCESS = 3'd6
  } state_e;

  localparam logic [2:0] APB_PROT = 3'b001;
  localparam logic [3:0] STRB_ALL = 4'hF;

  localparam int unsigned DEF_ID_WIDTH = 6;
  typedef logic [DEF_ID_WIDTH-1:0] irq_id_t;

  // Width of a down/up counter that must be able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/plic_apb_xfer.sv
// Single-transfer APB initiator: one req pulse launches SETUP then ACCESS,
// done/err report completion, slave error or an ACCESS-phase timeout.
module plic_apb_xfer
  import plic_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk_i,
  input  logic                  prst_i,
  input  logic                  req,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  done,
  output logic                  err,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [3:0]            pstrb_o,
  output logic [2:0]            pprot_o,
  input  logic                  pready_i,
  input  logic                  pslv_err_i
);

  localparam int TW = cnt_width(TIMEOUT);

  logic                  psel_reg;
  logic                  penable_reg;
  logic                  pwrite_reg;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic [3:0]            pstrb_reg;
  logic [2:0]            pprot_reg;
  logic [TW-1:0]         tmo_cnt_reg;
  logic                  tmo_hit;

  // The TIMEOUT-th ACCESS cycle without pready ends the transfer.
  assign tmo_hit = (tmo_cnt_reg == TW'(TIMEOUT - 1));
  assign done    = penable_reg && (pready_i || tmo_hit);
  assign err     = done && (!pready_i || pslv_err_i);

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      pstrb_reg   <= '0;
      pprot_reg   <= '0;
      tmo_cnt_reg <= '0;
    end else if (req) begin
      psel_reg    <= 1'b1;
      penable_reg <= 1'b0;
      pwrite_reg  <= req_write;
      paddr_reg   <= req_addr;
      pwdata_reg  <= req_wdata;
      pstrb_reg   <= req_write ? STRB_ALL : 4'h0;
      pprot_reg   <= APB_PROT;
      tmo_cnt_reg <= '0;
    end else if (done) begin
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
    end else if (penable_reg) begin
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
    end else if (psel_reg) begin
      penable_reg <= 1'b1;
    end
  end

  assign psel_o    = psel_reg;
  assign penable_o = penable_reg;
  assign pwrite_o  = pwrite_reg;
  assign paddr_o   = paddr_reg;
  assign pwdata_o  = pwdata_reg;
  assign pstrb_o   = pstrb_reg;
  assign pprot_o   = pprot_reg;

endmodule

// File: rtl/plic_hart_claim_master.sv
// Services one PLIC hart context: claims a pending ID over APB, hands it to
// the core, then writes the completion ID back to the claim/complete register.
module plic_hart_claim_master
  import plic_master_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 6,
  parameter logic [ADDR_WIDTH-1:0] CLAIM_ADDR = 32'hC020_0004,
  parameter int                    TIMEOUT    = 16,
  parameter int                    GAP        = 2
) (
  input  logic                  pclk_i,
  input  logic                  prst_i,
  input  logic                  en_i,
  input  logic                  irq_i,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [3:0]            pstrb_o,
  output logic [2:0]            pprot_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslv_err_i,
  output logic                  claim_valid_o,
  input  logic                  claim_ready_i,
  output logic [ID_WIDTH-1:0]   claim_id_o,
  input  logic                  cmpl_valid_i,
  output logic                  cmpl_ready_o,
  input  logic [ID_WIDTH-1:0]   cmpl_id_i,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int GW = cnt_width(GAP);

  state_e                state_reg, state_next;
  logic [GW-1:0]         gap_reg;
  logic [ID_WIDTH-1:0]   claim_id_reg;
  logic                  err_reg;
  logic                  xfer_req;
  logic                  xfer_write;
  logic [DATA_WIDTH-1:0] xfer_wdata;
  logic                  xfer_done;
  logic                  xfer_err;
  logic [ID_WIDTH-1:0]   rd_id;
  logic                  rd_claim_ok;

  // Only the ID field of the claim register carries meaning.
  logic unused_prdata_hi;
  assign unused_prdata_hi = ^prdata_i[DATA_WIDTH-1:ID_WIDTH];
  assign rd_id            = prdata_i[ID_WIDTH-1:0];
  assign rd_claim_ok      = xfer_done && !xfer_err && (rd_id != '0);

  plic_apb_xfer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) u_xfer (
    .pclk_i     (pclk_i),
    .prst_i     (prst_i),
    .req        (xfer_req),
    .req_write  (xfer_write),
    .req_addr   (CLAIM_ADDR),
    .req_wdata  (xfer_wdata),
    .done       (xfer_done),
    .err        (xfer_err),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .paddr_o    (paddr_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .pprot_o    (pprot_o),
    .pready_i   (pready_i),
    .pslv_err_i (pslv_err_i)
  );

  always_comb begin
    state_next = state_reg;
    xfer_req   = 1'b0;
    xfer_write = 1'b0;
    xfer_wdata = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if ((gap_reg == '0) && en_i && irq_i) begin
          state_next = ST_RD_SETUP;
          xfer_req   = 1'b1;
        end
      end
      ST_RD_SETUP:  state_next = ST_RD_ACCESS;
      ST_RD_ACCESS: begin
        // Error, timeout and a spurious zero ID all abandon the claim.
        if (xfer_done) state_next = rd_claim_ok ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (claim_ready_i) state_next = ST_WAIT_CMPL;
      end
      ST_WAIT_CMPL: begin
        if (cmpl_valid_i) begin
          state_next = ST_WR_SETUP;
          xfer_req   = 1'b1;
          xfer_write = 1'b1;
          xfer_wdata = {{(DATA_WIDTH - ID_WIDTH){1'b0}}, cmpl_id_i};
        end
      end
      ST_WR_SETUP:  state_next = ST_WR_ACCESS;
      ST_WR_ACCESS: begin
        if (xfer_done) state_next = ST_IDLE;
      end
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_reg    <= ST_IDLE;
      gap_reg      <= GW'(GAP);
      claim_id_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= xfer_done && xfer_err;
      // Give the PLIC time to update irq after each claim or completion.
      if ((state_next == ST_IDLE) && (state_reg != ST_IDLE)) begin
        gap_reg <= GW'(GAP);
      end else if ((state_reg == ST_IDLE) && (gap_reg != '0)) begin
        gap_reg <= gap_reg - GW'(1);
      end
      if ((state_reg == ST_RD_ACCESS) && rd_claim_ok) begin
        claim_id_reg <= rd_id;
      end
    end
  end

  assign claim_valid_o = (state_reg == ST_HOLD);
  assign claim_id_o    = claim_id_reg;
  assign cmpl_ready_o  = (state_reg == ST_WAIT_CMPL);
  assign err_o         = err_reg;
  assign busy_o        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_plic_hart_claim_master.sv
// Bench for plic_hart_claim_master: APB slave and core models, scoreboarded
// APB transfers and claims, directed gap/timeout/reset scenarios.
module tb_plic_hart_claim_master;

  localparam logic [31:0] CLAIM = 32'hC020_0004;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          acc;
  } apb_exp_t;

  typedef struct {
    logic [5:0] id;
    int         cycles;
  } clm_exp_t;

  logic        pclk_i = 1'b0;
  logic        prst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        irq_i = 1'b0;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslv_err_i = 1'b0;
  logic        claim_valid_o;
  logic        claim_ready_i = 1'b0;
  logic [5:0]  claim_id_o;
  logic        cmpl_valid_i = 1'b0;
  logic        cmpl_ready_o;
  logic [5:0]  cmpl_id_i = '0;
  logic        err_o, busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  // Slave and core model knobs
  int          slv_rd_wait = 0;
  int          slv_wr_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_wr_err = 1'b0;
  logic        slv_never = 1'b0;
  int          core_delay = 0;
  logic [5:0]  cmpl_val = '0;

  apb_exp_t apb_q[$];
  clm_exp_t clm_q[$];

  plic_hart_claim_master dut (
    .pclk_i        (pclk_i),
    .prst_i        (prst_i),
    .en_i          (en_i),
    .irq_i         (irq_i),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .pwrite_o      (pwrite_o),
    .paddr_o       (paddr_o),
    .pwdata_o      (pwdata_o),
    .pstrb_o       (pstrb_o),
    .pprot_o       (pprot_o),
    .prdata_i      (prdata_i),
    .pready_i      (pready_i),
    .pslv_err_i    (pslv_err_i),
    .claim_valid_o (claim_valid_o),
    .claim_ready_i (claim_ready_i),
    .claim_id_o    (claim_id_o),
    .cmpl_valid_i  (cmpl_valid_i),
    .cmpl_ready_o  (cmpl_ready_o),
    .cmpl_id_i     (cmpl_id_i),
    .err_o         (err_o),
    .busy_o        (busy_o)
  );

  initial forever #5 pclk_i = ~pclk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_rd(input int acc);
    apb_q.push_back('{wr: 1'b0, addr: CLAIM, data: 32'h0, acc: acc});
  endtask

  task automatic push_wr(input logic [31:0] data, input int acc);
    apb_q.push_back('{wr: 1'b1, addr: CLAIM, data: data, acc: acc});
  endtask

  task automatic push_clm(input logic [5:0] id, input int cycles);
    clm_q.push_back('{id: id, cycles: cycles});
  endtask

  task automatic wait_psel(input string tag);
    int n = 0;
    while (!psel_o && n < 50) begin
      @(negedge pclk_i);
      n++;
    end
    check_eq({tag, "_psel_seen"}, psel_o, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_o || apb_q.size() != 0 || clm_q.size() != 0) && n < 300) begin
      @(negedge pclk_i);
      n++;
    end
    check_eq({tag, "_idle"}, (n < 300), 1);
    repeat (2) @(negedge pclk_i);
  endtask

  // APB slave: pready after a configurable number of wait cycles
  initial begin
    int acc;
    acc = 0;
    forever begin
      @(negedge pclk_i);
      if (psel_o && penable_o) begin
        pready_i   = !slv_never && (acc >= (pwrite_o ? slv_wr_wait : slv_rd_wait));
        prdata_i   = slv_rdata;
        pslv_err_i = pready_i && pwrite_o && slv_wr_err;
        acc++;
      end else begin
        pready_i   = 1'b0;
        pslv_err_i = 1'b0;
        prdata_i   = '0;
        acc        = 0;
      end
    end
  end

  // Core: accepts a claim after core_delay cycles, then requests completion of cmpl_val
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge pclk_i);
      if (claim_ready_i) begin
        claim_ready_i = 1'b0;
        c = 0;
      end else if (claim_valid_o) begin
        if (c == core_delay) claim_ready_i = 1'b1;
        else c++;
      end
      if (cmpl_valid_i) begin
        cmpl_valid_i = 1'b0;
      end else if (cmpl_ready_o) begin
        cmpl_valid_i = 1'b1;
        cmpl_id_i    = cmpl_val;
      end
    end
  end

  // APB monitor
  initial begin
    int acc_m;
    apb_exp_t e;
    acc_m = 0;
    forever begin
      @(negedge pclk_i);
      #1;
      if (prst_i || !psel_o) begin
        acc_m = 0;
      end else if (penable_o) begin
        acc_m++;
        if (pready_i) begin
          check_eq("apb_expected", (apb_q.size() != 0), 1);
          if (apb_q.size() != 0) begin
            e = apb_q.pop_front();
            check_eq("apb_write", pwrite_o, e.wr);
            check_eq("apb_addr", paddr_o, e.addr);
            if (e.wr) check_eq("apb_wdata", pwdata_o, e.data);
            check_eq("apb_strb", pstrb_o, e.wr ? 4'hF : 4'h0);
            check_eq("apb_prot", pprot_o, 3'b001);
            check_eq("apb_access_cycles", acc_m, e.acc);
          end
          $display("apb %s addr=0x%08h wdata=0x%08h rdata=0x%08h access=%0d err=%0b",
                   pwrite_o ? "wr" : "rd", paddr_o, pwdata_o, prdata_i, acc_m, pslv_err_i);
          acc_m = 0;
        end
      end
    end
  end

  // Claim monitor
  initial begin
    int v;
    clm_exp_t e;
    v = 0;
    forever begin
      @(negedge pclk_i);
      #1;
      if (claim_valid_o) begin
        v++;
        if (claim_ready_i) begin
          check_eq("claim_expected", (clm_q.size() != 0), 1);
          if (clm_q.size() != 0) begin
            e = clm_q.pop_front();
            check_eq("claim_id", claim_id_o, e.id);
            check_eq("claim_hold_cycles", v, e.cycles);
          end
          $display("claim id=%0d valid_cycles=%0d", claim_id_o, v);
          v = 0;
        end
      end else begin
        v = 0;
      end
    end
  end

  // Error pulse monitor
  initial begin
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge pclk_i);
      #1;
      if (err_o) begin
        check_eq("err_single_cycle", err_prev, 0);
        err_seen++;
        $display("err pulse #%0d", err_seen);
      end
      err_prev = err_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int err_before;

    // Reset state
    repeat (3) @(negedge pclk_i);
    check_eq("rst_ctrl", {psel_o, penable_o, pwrite_o, pstrb_o, pprot_o,
                          claim_valid_o, cmpl_ready_o, err_o, busy_o}, 0);
    check_eq("rst_paddr", paddr_o, 0);
    check_eq("rst_pwdata", pwdata_o, 0);
    check_eq("rst_claim_id", claim_id_o, 0);
    prst_i = 1'b0;
    en_i   = 1'b1;
    repeat (5) @(negedge pclk_i);

    // Basic claim/complete, one-cycle launch latency from a settled IDLE
    slv_rdata = 32'h2; cmpl_val = 6'd2;
    push_rd(1); push_clm(6'd2, 1); push_wr(32'h2, 1);
    irq_i = 1'b1;
    cnt = 0;
    do begin
      @(negedge pclk_i);
      cnt++;
    end while (!psel_o && cnt < 20);
    check_eq("t1_launch_latency", cnt, 1);
    irq_i = 1'b0;
    wait_idle("t1");

    // Wait states on read, upper prdata bits ignored, core stalls 5 cycles
    slv_rd_wait = 3; slv_wr_wait = 1; slv_rdata = 32'hABCD_0007;
    core_delay = 5; cmpl_val = 6'd7;
    push_rd(4); push_clm(6'd7, 6); push_wr(32'h7, 2);
    irq_i = 1'b1;
    wait_psel("t2");
    irq_i = 1'b0;
    wait_idle("t2");
    slv_rd_wait = 0; slv_wr_wait = 0; core_delay = 0;

    // Spurious zero ID: no claim, retry after the gap while irq stays high
    slv_rdata = 32'h0; cmpl_val = 6'd5;
    push_rd(1); push_rd(1); push_clm(6'd5, 1); push_wr(32'h5, 1);
    irq_i = 1'b1;
    wait_psel("t3");
    cnt = 0;
    while (psel_o && cnt < 50) begin
      @(negedge pclk_i);
      cnt++;
    end
    slv_rdata = 32'h5;
    cnt = 0;
    while (!psel_o && cnt < 20) begin
      cnt++;
      @(negedge pclk_i);
    end
    check_eq("t3_gap_cycles", cnt, 3);
    irq_i = 1'b0;
    wait_idle("t3");

    // Completion ID differs from claim, slave errors the completion write
    err_before = err_seen;
    slv_rdata = 32'h9; cmpl_val = 6'd3; slv_wr_err = 1'b1;
    push_rd(1); push_clm(6'd9, 1); push_wr(32'h3, 1);
    irq_i = 1'b1;
    wait_psel("t4");
    irq_i = 1'b0;
    wait_idle("t4");
    slv_wr_err = 1'b0;
    check_eq("t4_err_pulses", err_seen - err_before, 1);
    check_eq("t4_busy", busy_o, 0);

    // en_i low blocks new claims
    en_i = 1'b0; irq_i = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge pclk_i);
      if (psel_o) cnt++;
    end
    check_eq("t5_disabled_psel", cnt, 0);
    irq_i = 1'b0; en_i = 1'b1;
    repeat (2) @(negedge pclk_i);

    // Slave never ready: abort after 16 ACCESS cycles
    slv_never = 1'b1;
    irq_i = 1'b1;
    wait_psel("t6");
    irq_i = 1'b0;
    cnt = 0;
    while (psel_o && cnt < 40) begin
      if (penable_o) cnt++;
      @(negedge pclk_i);
    end
    check_eq("t6_access_cycles", cnt, 16);
    check_eq("t6_err_on_abort", err_o, 1);
    check_eq("t6_busy_after_abort", busy_o, 0);
    @(negedge pclk_i);
    check_eq("t6_err_cleared", err_o, 0);
    slv_never = 1'b0;
    repeat (3) @(negedge pclk_i);

    // Reset during completion write, then a fresh claim after release and gap
    slv_rdata = 32'h4; cmpl_val = 6'd4; slv_wr_wait = 8;
    push_rd(1); push_clm(6'd4, 1);
    irq_i = 1'b1;
    cnt = 0;
    while (!(psel_o && penable_o && pwrite_o) && cnt < 100) begin
      @(negedge pclk_i);
      cnt++;
    end
    check_eq("t7_in_wr_access", (psel_o && penable_o && pwrite_o), 1);
    #2;
    prst_i = 1'b1;
    #1;
    check_eq("t7_rst_psel_penable", {psel_o, penable_o}, 0);
    check_eq("t7_rst_busy", busy_o, 0);
    slv_wr_wait = 1;
    push_rd(1); push_clm(6'd4, 1); push_wr(32'h4, 2);
    repeat (2) @(negedge pclk_i);
    prst_i = 1'b0;
    cnt = 0;
    do begin
      @(negedge pclk_i);
      cnt++;
    end while (!psel_o && cnt < 20);
    check_eq("t7_rst_gap", cnt, 3);
    irq_i = 1'b0;
    wait_idle("t7");

    check_eq("total_err_pulses", err_seen, 2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
